// File: rtl/cpu_sequencer.sv
// Control FSM for the 8-bit teaching computer: fetches over a req/ack handshake,
// sequences two-byte instructions and branches, and drives register-file/ALU/output controls.
module cpu_sequencer #(
    parameter logic [7:0]  RESET_PC      = 8'h00,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic [7:0] iaddr,
    input  logic [7:0] instr_in,
    output logic [7:0] instruction,
    output logic [2:0] opcode,
    output logic [1:0] operand_1,
    output logic [1:0] operand_2,
    output logic [1:0] alu_mode,
    input  logic       alu_zero,
    output logic       rf_we,
    output logic       rf_wsel,
    output logic [7:0] imm,
    input  logic [7:0] rf_rdata_a,
    output logic [1:0] oaddr,
    output logic [7:0] oport,
    output logic       oport_valid,
    output logic [2:0] state,
    output logic       halted,
    output logic       fault
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_DECODE    = 3'b001,
        S_FETCH_IMM = 3'b010,
        S_EXECUTE   = 3'b011,
        S_HALT      = 3'b100
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt;
    logic              zflag;
    logic              timeout_hit;
    logic              is_alu, is_ldi, is_out, is_jnz, is_halt;

    // Instruction field decode from the latched byte
    assign opcode    = instruction[7:5];
    assign operand_1 = instruction[3:2];
    assign operand_2 = instruction[1:0];
    assign is_alu    = (opcode >= 3'd1) && (opcode <= 3'd4);
    assign is_ldi    = (opcode == 3'd5);
    assign is_out    = (opcode == 3'd6);
    assign is_jnz    = (opcode == 3'd7) && !instruction[4];
    assign is_halt   = (opcode == 3'd7) && instruction[4];

    assign state  = state_q;
    assign halted = (state_q == S_HALT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state controls
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 1'b0;
        timeout_hit = 1'b0;
        alu_mode    = 2'b00;
        if (is_alu) begin
            alu_mode = 2'(opcode - 3'd1);
        end
        case (state_q)
            S_FETCH, S_FETCH_IMM: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE : S_EXECUTE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_ldi || is_jnz) begin
                    state_d = S_FETCH_IMM;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                rf_we   = is_alu || is_ldi;
                rf_wsel = is_ldi;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Program counter, fetched bytes, flags, timeout counter and output port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iaddr       <= RESET_PC;
            instruction <= 8'h00;
            imm         <= 8'h00;
            zflag       <= 1'b0;
            wait_cnt    <= '0;
            oport       <= 8'h00;
            oaddr       <= 2'b00;
            oport_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            oport_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (imem_req && imem_ack) begin
                iaddr <= iaddr + 8'd1;
                if (state_q == S_FETCH) begin
                    instruction <= instr_in;
                end else begin
                    imm <= instr_in;
                end
            end
            if (timeout_hit) begin
                fault <= 1'b1;
            end
            if (state_q == S_EXECUTE) begin
                if (is_alu) begin
                    zflag <= alu_zero;
                end
                if (is_out) begin
                    oport       <= rf_rdata_a;
                    oaddr       <= operand_1;
                    oport_valid <= 1'b1;
                end
                if (is_jnz && !zflag) begin
                    iaddr <= imm;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random forward-branching programs,
// checked against an instruction-level interpreter with a per-instruction cycle cost.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 00)
    logic       reset, imem_req, imem_ack, alu_zero, rf_we, rf_wsel, oport_valid, halted, fault;
    logic [7:0] iaddr, instr_in, instruction, imm, rf_rdata_a, oport;
    logic [2:0] opcode, state;
    logic [1:0] operand_1, operand_2, alu_mode, oaddr;

    // Second instance (RESET_PC = FF)
    logic       reset_b, imem_req_b, imem_ack_b, alu_zero_b, rf_we_b, rf_wsel_b, oport_valid_b, halted_b, fault_b;
    logic [7:0] iaddr_b, instr_in_b, instruction_b, imm_b, rf_rdata_a_b, oport_b;
    logic [2:0] opcode_b, state_b;
    logic [1:0] operand_1_b, operand_2_b, alu_mode_b, oaddr_b;

    cpu_sequencer u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack), .iaddr(iaddr),
        .instr_in(instr_in), .instruction(instruction), .opcode(opcode), .operand_1(operand_1),
        .operand_2(operand_2), .alu_mode(alu_mode), .alu_zero(alu_zero), .rf_we(rf_we),
        .rf_wsel(rf_wsel), .imm(imm), .rf_rdata_a(rf_rdata_a), .oaddr(oaddr), .oport(oport),
        .oport_valid(oport_valid), .state(state), .halted(halted), .fault(fault)
    );

    cpu_sequencer #(.RESET_PC(8'hFF), .FETCH_TIMEOUT(15)) u_dut_ff (
        .clk(clk), .reset(reset_b), .imem_req(imem_req_b), .imem_ack(imem_ack_b), .iaddr(iaddr_b),
        .instr_in(instr_in_b), .instruction(instruction_b), .opcode(opcode_b), .operand_1(operand_1_b),
        .operand_2(operand_2_b), .alu_mode(alu_mode_b), .alu_zero(alu_zero_b), .rf_we(rf_we_b),
        .rf_wsel(rf_wsel_b), .imm(imm_b), .rf_rdata_a(rf_rdata_a_b), .oaddr(oaddr_b), .oport(oport_b),
        .oport_valid(oport_valid_b), .state(state_b), .halted(halted_b), .fault(fault_b)
    );

    int tests = 0;
    int fails = 0;

    // Instruction memory with a configurable number of wait cycles before ack
    logic [7:0] mem [256];
    int         wait_cycles;
    int         wait_cnt;
    bit         ack_en;
    logic [7:0] junk;

    always_comb begin
        imem_ack   = imem_req && ack_en && (wait_cnt >= wait_cycles);
        instr_in   = imem_ack ? mem[iaddr] : junk;
        imem_ack_b = imem_req_b;
        instr_in_b = mem[iaddr_b];
    end

    always @(posedge clk) begin
        if (!reset || !(imem_req && !imem_ack)) wait_cnt <= 0;
        else                                    wait_cnt <= wait_cnt + 1;
    end

    // Register file and ALU of the surrounding datapath
    logic [7:0] regs [4];
    logic [7:0] alu_res;

    always_comb begin
        case (alu_mode)
            2'b00:   alu_res = regs[operand_1] + regs[operand_2];
            2'b01:   alu_res = regs[operand_1] - regs[operand_2];
            2'b10:   alu_res = regs[operand_1] & regs[operand_2];
            default: alu_res = regs[operand_1] | regs[operand_2];
        endcase
        alu_zero   = (alu_res == 8'h00);
        rf_rdata_a = regs[operand_1];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (rf_we) begin
            regs[operand_1] <= rf_wsel ? imm : alu_res;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: architectural effects plus cycles until HALT is entered
    logic [7:0] exp_oport [$];
    logic [1:0] exp_oaddr [$];
    logic [7:0] m_regs [4];
    logic [7:0] m_pc;
    int         m_cycles;

    task automatic model_run(input int w);
        logic [7:0] pc, ins, im;
        logic [7:0] r [4];
        logic [1:0] ra, rb;
        bit         z;
        pc = 8'h00;
        z  = 1'b0;
        for (int i = 0; i < 4; i++) r[i] = 8'h00;
        m_cycles = 0;
        exp_oport.delete();
        exp_oaddr.delete();
        for (int step = 0; step < 400; step++) begin
            ins = mem[pc];
            pc  = pc + 8'd1;
            m_cycles += w + 2;
            if (ins[7:5] == 3'd7 && ins[4]) break;
            if (ins[7:5] == 3'd5 || ins[7:5] == 3'd7) begin
                im = mem[pc];
                pc = pc + 8'd1;
                m_cycles += w + 1;
            end
            m_cycles += 1;
            ra = ins[3:2];
            rb = ins[1:0];
            case (ins[7:5])
                3'd1: begin r[ra] = r[ra] + r[rb]; z = (r[ra] == 8'h00); end
                3'd2: begin r[ra] = r[ra] - r[rb]; z = (r[ra] == 8'h00); end
                3'd3: begin r[ra] = r[ra] & r[rb]; z = (r[ra] == 8'h00); end
                3'd4: begin r[ra] = r[ra] | r[rb]; z = (r[ra] == 8'h00); end
                3'd5: r[ra] = im;
                3'd6: begin exp_oport.push_back(r[ra]); exp_oaddr.push_back(ra); end
                3'd7: if (!z) pc = im;
                default: ;
            endcase
        end
        m_pc = pc;
        for (int i = 0; i < 4; i++) m_regs[i] = r[i];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    // Random program with forward-only branches so it always reaches HALT
    task automatic gen_prog();
        int         n, a, tgt;
        int         kind [12];
        int         addr [13];
        logic [7:0] b0;
        clear_mem();
        n = int'($urandom_range(10, 4));
        a = 0;
        for (int i = 0; i < n; i++) begin
            kind[i] = int'($urandom_range(7, 0));
            addr[i] = a;
            a += (kind[i] == 5 || kind[i] == 7) ? 2 : 1;
        end
        addr[n] = a;
        mem[a] = {4'hF, 4'($urandom)};
        for (int i = 0; i < n; i++) begin
            if (kind[i] == 7) b0 = {4'hE, 4'($urandom)};
            else              b0 = {3'(kind[i]), 5'($urandom)};
            mem[addr[i]] = b0;
            if (kind[i] == 5) mem[addr[i] + 1] = 8'($urandom_range(3, 0));
            if (kind[i] == 7) begin
                tgt = int'($urandom_range(n, i + 1));
                mem[addr[i] + 1] = 8'(addr[tgt]);
            end
        end
    endtask

    // Runs the program in mem from reset and compares against the reference
    task automatic run_prog(input int w, input string tag);
        int n, pulses, nexp;
        bit done;
        reset = 1'b0;
        ack_en = 1'b1;
        wait_cycles = w;
        junk = 8'($urandom);
        model_run(w);
        nexp = exp_oport.size();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        pulses = 0;
        done = 1'b0;
        while (n < m_cycles + 40 && !done) begin
            @(negedge clk);
            n++;
            if (oport_valid) begin
                pulses++;
                if (exp_oport.size() > 0) begin
                    check({tag, "_oport"}, 32'(oport), 32'(exp_oport.pop_front()));
                    check({tag, "_oaddr"}, 32'(oaddr), 32'(exp_oaddr.pop_front()));
                end
            end
            if (halted) done = 1'b1;
        end
        check({tag, "_halted"}, 32'(done), 1);
        check({tag, "_cycles"}, n, m_cycles);
        check({tag, "_pulses"}, pulses, nexp);
        check({tag, "_fault"}, 32'(fault), 0);
        check({tag, "_iaddr"}, 32'(iaddr), 32'(m_pc));
        for (int i = 0; i < 4; i++) check({tag, "_reg"}, 32'(regs[i]), 32'(m_regs[i]));
    endtask

    initial begin
        bit found;
        reset = 1'b0;
        reset_b = 1'b0;
        ack_en = 1'b1;
        wait_cycles = 0;
        junk = 8'h00;
        alu_zero_b = 1'b0;
        rf_rdata_a_b = 8'h00;
        clear_mem();
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_state", 32'(state), 0);
        check("rst_iaddr", 32'(iaddr), 0);
        check("rst_instr", 32'(instruction), 0);
        check("rst_imm", 32'(imm), 0);
        check("rst_oport", 32'(oport), 0);
        check("rst_oaddr", 32'(oaddr), 0);
        check("rst_ovalid", 32'(oport_valid), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_rfwe", 32'(rf_we), 0);
        check("rst_iaddr_ff", 32'(iaddr_b), 32'hFF);

        // LDI R1,#05; LDI R2,#03; ADD R1,R2; OUT R1; HALT
        clear_mem();
        mem[0] = 8'hA4; mem[1] = 8'h05; mem[2] = 8'hA8; mem[3] = 8'h03;
        mem[4] = 8'h26; mem[5] = 8'hC4; mem[6] = 8'hF0;
        run_prog(0, "p1");
        check("p1_oport_08", 32'(oport), 32'h08);
        check("p1_oaddr_01", 32'(oaddr), 1);
        check("p1_iaddr_07", 32'(iaddr), 7);
        run_prog(2, "p1w");

        // Three wait cycles on an ADD fetch
        clear_mem();
        mem[0] = 8'h26;
        reset = 1'b0;
        wait_cycles = 3;
        junk = 8'h5A;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("ws_req", 32'(imem_req), 1);
            check("ws_iaddr", 32'(iaddr), 0);
            check("ws_instr", 32'(instruction), 0);
            check("ws_state", 32'(state), 0);
        end
        @(negedge clk);
        check("ws_dec_state", 32'(state), 1);
        check("ws_dec_instr", 32'(instruction), 32'h26);
        check("ws_dec_iaddr", 32'(iaddr), 1);
        @(negedge clk);
        check("ws_exe_state", 32'(state), 3);
        check("ws_exe_rfwe", 32'(rf_we), 1);
        check("ws_exe_mode", 32'(alu_mode), 0);
        @(negedge clk);
        check("ws_done_state", 32'(state), 0);
        check("ws_done_iaddr", 32'(iaddr), 1);

        // Countdown loop: JNZ taken twice, falls through on the third pass
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h03; mem[2] = 8'hA4; mem[3] = 8'h01;
        mem[4] = 8'h41; mem[5] = 8'hE0; mem[6] = 8'h04; mem[7] = 8'hF0;
        run_prog(0, "loop");
        check("loop_iaddr_08", 32'(iaddr), 8);
        check("loop_r0", 32'(regs[0]), 0);
        run_prog(1, "loopw");

        // Fetch timeout with ack held low
        clear_mem();
        reset = 1'b0;
        ack_en = 1'b0;
        wait_cycles = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("to_halted", 32'(halted), 32'(k == 15));
        end
        check("to_fault", 32'(fault), 1);
        check("to_state", 32'(state), 4);
        check("to_req", 32'(imem_req), 0);
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        check("to_absorb", 32'(state), 4);

        // Ack on the 15th request cycle wins over the timeout
        mem[0] = 8'h00;
        reset = 1'b0;
        wait_cycles = 14;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        check("ack15_fetch", 32'(state), 0);
        @(negedge clk);
        check("ack15_state", 32'(state), 1);
        check("ack15_fault", 32'(fault), 0);

        // Reset asserted during EXECUTE of ADD
        clear_mem();
        mem[0] = 8'hA4; mem[1] = 8'h05; mem[2] = 8'hC4; mem[3] = 8'h26;
        reset = 1'b0;
        wait_cycles = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (state == 3'd3 && instruction == 8'h26) found = 1'b1;
        end
        check("mid_found", 32'(found), 1);
        check("mid_rfwe", 32'(rf_we), 1);
        check("mid_oport", 32'(oport), 5);
        reset = 1'b0;
        #1;
        check("mid_rst_rfwe", 32'(rf_we), 0);
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_iaddr", 32'(iaddr), 0);
        check("mid_rst_oport", 32'(oport), 0);

        // RESET_PC = FF: LDI at FF with its immediate at 00
        clear_mem();
        mem[8'hFF] = 8'hA4;
        mem[8'h00] = 8'h3C;
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        check("ff_dec_state", 32'(state_b), 1);
        check("ff_dec_iaddr", 32'(iaddr_b), 0);
        check("ff_dec_instr", 32'(instruction_b), 32'hA4);
        @(negedge clk);
        check("ff_imm_state", 32'(state_b), 2);
        @(negedge clk);
        check("ff_exe_state", 32'(state_b), 3);
        check("ff_exe_imm", 32'(imm_b), 32'h3C);
        check("ff_exe_iaddr", 32'(iaddr_b), 1);
        check("ff_exe_we", 32'(rf_we_b), 1);
        check("ff_exe_wsel", 32'(rf_wsel_b), 1);
        reset_b = 1'b0;

        // Random programs with random memory latency
        for (int r = 0; r < 8; r++) begin
            gen_prog();
            run_prog(int'($urandom_range(3, 0)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Control FSM for the 8-bit teaching computer. It fetches instructions from instruction memory over a req/ack handshake and decodes them into register-file, ALU-mode and output-port controls. It also sequences multi-byte instructions and branches. It sits between instruction memory and the register-file/ALU datapath inside `computer`, and drives the `oport` byte.

Parameters:
RESET_PC, 8'h00, iaddr value loaded on reset
FETCH_TIMEOUT, 15, max cycles imem_req may stay unacknowledged before fault; range 1..255

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  instruction-memory read request
imem_ack  input  1  memory has placed the byte for iaddr on instr_in this cycle
iaddr  output  8  program counter / instruction-memory address
instr_in  input  8  instruction-memory read data
instruction  output  8  latched current instruction byte
opcode  output  3  instruction[7:5]
operand_1  output  2  instruction[3:2], register A (read addr and write addr)
operand_2  output  2  instruction[1:0], register B (read addr)
alu_mode  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
alu_zero  input  1  ALU result is zero (combinational from datapath)
rf_we  output  1  register-file write strobe, one cycle
rf_wsel  output  1  0 = write ALU result, 1 = write imm
imm  output  8  latched immediate byte
rf_rdata_a  input  8  register-file read data at operand_1
oaddr  output  2  register sourced by last OUT
oport  output  8  output port register
oport_valid  output  1  one-cycle pulse when oport updates
state  output  3  FSM state
halted  output  1  FSM in HALT
fault  output  1  HALT entered via fetch timeout

Behaviour:
- ISA: opcode 000 NOP; 001 ADD; 010 SUB; 011 AND; 100 OR; 101 LDI A,#imm (2 bytes); 110 OUT A; 111 with instruction[4]=0 JNZ #target (2 bytes); 111 with [4]=1 HALT.
- ALU ops compute A <= A op B.
- State encoding: FETCH 000, DECODE 001, FETCH_IMM 010, EXECUTE 011, HALT 100.
- Reset (reset=0, async): state=FETCH, iaddr=RESET_PC. All other outputs 0, including zero flag, timeout counter, instruction, imm, oport and fault. Reset mid-instruction aborts it with no writes.
- FETCH:
  - imem_req=1, iaddr held stable.
  - On imem_ack: instruction<=instr_in, iaddr<=iaddr+1 (8-bit wrap, FF->00), go to DECODE.
- DECODE: one cycle.
  - LDI or JNZ -> FETCH_IMM.
  - HALT -> HALT.
  - All others -> EXECUTE.
- FETCH_IMM: imem_req=1. On ack: imm<=instr_in, iaddr<=iaddr+1, go to EXECUTE.
- EXECUTE: one cycle, then FETCH.
  - ALU ops: alu_mode set from opcode (001->00, 010->01, 011->10, 100->11), rf_we=1, rf_wsel=0, zero flag<=alu_zero.
  - LDI: rf_we=1, rf_wsel=1. Zero flag unchanged.
  - OUT: oport<=rf_rdata_a, oaddr<=operand_1, oport_valid=1 on the next cycle.
  - JNZ: if zero flag=0, iaddr<=imm; else fall through.
  - NOP: no effect.
- alu_mode is combinational from the latched opcode. It is 00 for non-ALU opcodes.
- rf_we is high only in EXECUTE.
- HALT: absorbing; imem_req=0, halted=1. Leave only via reset.
- Latency with zero-wait memory (ack in the same cycle as req): 1-byte instruction 3 cycles; LDI/JNZ 4 cycles. Each wait cycle adds 1.
- Timeout:
  - Counter clears on entry to FETCH/FETCH_IMM and on ack; it increments on each req cycle without ack.
  - When it reaches FETCH_TIMEOUT without ack, go to HALT with fault=1.
  - Ack in the same cycle as timeout: ack wins.
- imem_ack outside FETCH/FETCH_IMM is ignored.
- instr_in is sampled only on the ack cycle.

Test Plan:
- Reset then zero-wait program {LDI R1,#05; LDI R2,#03; ADD R1,R2; OUT R1; HALT} -> oport=08 with oaddr=01 and a single oport_valid pulse. HALT is reached at iaddr=07; halted=1, fault=0.
- Memory acks after 3 wait cycles -> imem_req and iaddr stable during the wait; instruction latches only on the ack cycle; ALU instruction completes in 6 cycles.
- Loop {LDI R0,#03; LDI R1,#01; SUB R0,R1; JNZ #04; HALT} -> JNZ taken twice and falls through on the third pass; HALT at iaddr=08.
- Hold imem_ack=0 -> HALT entered after exactly 15 req cycles with fault=1. Ack on cycle 15 -> normal DECODE, fault=0.
- Assert reset=0 during EXECUTE of ADD -> rf_we drops immediately; state=000, iaddr=00, oport=00 before the next edge.
- RESET_PC=8'hFF with LDI at FF and its imm byte at 00 -> immediate fetched from 00; iaddr wraps to 01.
